fram_portb_arbiter: RTL
=======================

Name: fram_portb_arbiter

Overview:
Shares port B of every feature-SRAM bank between two requesters:
- the decoder's broadcast feature reads (one bank address applied to all banks, feeding the PE lanes);
- the CU's single-word result writebacks.

Reads have strict priority and pass straight through. Writebacks are queued in an internal FIFO and retired in cycles with no read. The block back-pressures the decoder through wb_busy and reports drain completion after a flush.

Parameters:
- FRAM_ADDR_WIDTH, 14, word address width of the full feature SRAM.
- BANK_NUM, 4, number of feature banks (power of two).
- BANK_ADDR_WIDTH, 12, per-bank word address width (= FRAM_ADDR_WIDTH - log2(BANK_NUM)).
- DATA_WIDTH, 32, data word width.
- FIFO_DEPTH, 8, writeback queue entries (power of two, >= 4).
- BUSY_SLACK, 2, free entries at or below which wb_busy asserts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rd_req  in  1  decoder read this cycle.
- rd_bankaddr  in  BANK_ADDR_WIDTH  read address, broadcast to all banks.
- wb_valid  in  1  CU writeback strobe.
- wb_addr  in  FRAM_ADDR_WIDTH  writeback word address.
- wb_data  in  DATA_WIDTH  writeback data (signed result).
- flush  in  1  one-cycle pulse: decoder finished issuing; drain queue.
- wb_busy  out  1  back-pressure to the decoder.
- drain_done  out  1  one-cycle pulse: queue empty after flush.
- wb_overflow  out  1  sticky: a writeback was dropped.
- bram_addr  out  BANK_NUM x BANK_ADDR_WIDTH  per-bank port-B address.
- bram_wdata  out  BANK_NUM x DATA_WIDTH  per-bank port-B write data.
- bram_we  out  BANK_NUM  per-bank write enable.
- bram_en  out  BANK_NUM  per-bank enable.

Behaviour:
- Reset values:
  - bram_en, bram_we, bram_addr, bram_wdata: 0.
  - wb_busy, drain_done, wb_overflow: 0.
  - FIFO pointers and count: 0.
  - State: IDLE.
- Address split:
  - bank = wb_addr[log2(BANK_NUM)-1:0].
  - bank address = wb_addr[FRAM_ADDR_WIDTH-1:log2(BANK_NUM)].
- Read path:
  - rd_req=1 drives all bram_en=1, bram_we=0, bram_addr=rd_bankaddr combinationally in the same cycle. No added latency.
  - Read data returns from the BRAMs to the CU; it does not pass through this block.
- Push:
  - wb_valid=1 with count<FIFO_DEPTH writes {wb_addr, wb_data} at the tail.
  - A write issues no earlier than the cycle after its push (no bypass).
- Pop/issue:
  - In a cycle with rd_req=0 and count>0, the head entry drives one bank: en=1, we=1, addr=head bank address, wdata=head data. The entry is popped at the clock edge.
  - All other banks have en=0.
  - Strict FIFO order.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - wb_valid while count==FIFO_DEPTH and no pop that cycle drops the entry and sets wb_overflow.
  - wb_overflow is sticky until reset.
  - A push in a full-with-pop cycle is accepted.
- wb_busy (registered) = (FIFO_DEPTH-count_next <= BUSY_SLACK) OR state==DRAIN.
- State machine:
  - IDLE (count==0, no flush pending) -> ACTIVE on push.
  - ACTIVE -> IDLE when count becomes 0 without flush.
  - ACTIVE or IDLE -> DRAIN on flush.
  - DRAIN: wb_busy=1. Pushes are still accepted. When count==0 and wb_valid==0, pulse drain_done for 1 cycle and go to IDLE.
  - flush in IDLE with empty queue: drain_done the next cycle.
  - flush while already in DRAIN: ignored.
- Read/write hazards on the same bank address are not checked. Output and input regions are disjoint by construction upstream.
- Reset mid-operation: queue contents are discarded and all outputs return to reset values asynchronously.

Optional Feature:
- FRAM_ARB_STAT_EN defined: adds outputs stat_stall_cycles (32-bit) and stat_max_occupancy (log2(FIFO_DEPTH)+1 bits).
  - stat_stall_cycles counts cycles with count>0 and rd_req=1, saturating.
  - stat_max_occupancy holds the peak count.
  - Both clear on reset and on flush.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - typedef wb_entry_t {bank address, bank index, data};
  - function fram_bank_of(addr);
  - function fram_bankaddr_of(addr);
  - state enum {IDLE, ACTIVE, DRAIN}.
- Natural sub-module: sync_fifo (parameterised width/depth, full/empty/count).
- Arbitration and FSM live in this module.

Test Plan:
- Writeback without reads:
  - Stimulus: wb_valid with addr 0x0005, data 0x1234, no rd_req.
  - Response: cycle+1 bram_en=0b0010, bram_we=0b0010, bram_addr[1]=0x001, bram_wdata[1]=0x1234.
- Read priority:
  - Stimulus: 3 pushes, then rd_req held 4 cycles with rd_bankaddr=0x0A0.
  - Response: all banks en=1, we=0, addr=0x0A0 during the reads. The 3 writes issue in order on the 3 cycles after rd_req drops.
- Back-pressure and overflow:
  - Stimulus: rd_req held high, 9 pushes.
  - Response: wb_busy=1 after the 6th push. wb_overflow=1 after the 9th. Only 8 entries are written after rd_req drops.
- Simultaneous push/pop with wrap:
  - Stimulus: 20 back-to-back pushes, no reads.
  - Response: count stays 1, no overflow, 20 writes in order.
- Flush:
  - Stimulus: 2 entries queued, rd_req=1, then flush.
  - Response: wb_busy=1 immediately. drain_done pulses exactly one cycle after the last write issues. State returns to IDLE with wb_busy=0.
- Reset mid-drain:
  - Stimulus: rst_n low while 5 entries are queued.
  - Response: all outputs 0 asynchronously, and no writes issue after release.

Source files
------------

// File: rtl/fram_portb_arbiter_pkg.sv
// Shared types and address helpers for the feature-SRAM port-B arbiter.
package fram_portb_arbiter_pkg;

  localparam int unsigned FRAM_ADDR_W = 14;
  localparam int unsigned BANK_N      = 4;
  localparam int unsigned BANK_SEL_W  = $clog2(BANK_N);
  localparam int unsigned BANK_ADDR_W = FRAM_ADDR_W - BANK_SEL_W;
  localparam int unsigned DATA_W      = 32;

  typedef struct packed {
    logic [BANK_ADDR_W-1:0] bank_addr;
    logic [BANK_SEL_W-1:0]  bank;
    logic [DATA_W-1:0]      data;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} arb_state_t;

  function automatic logic [BANK_SEL_W-1:0] fram_bank_of(input logic [FRAM_ADDR_W-1:0] addr);
    return addr[BANK_SEL_W-1:0];
  endfunction

  function automatic logic [BANK_ADDR_W-1:0] fram_bankaddr_of(input logic [FRAM_ADDR_W-1:0] addr);
    return addr[FRAM_ADDR_W-1:BANK_SEL_W];
  endfunction

endpackage

// File: rtl/fram_portb_arbiter_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is taken only with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fram_portb_arbiter.sv
// Port-B arbiter: broadcast reads win, CU writebacks queue and retire in idle cycles.
// Optional statistics outputs are enabled by defining FRAM_ARB_STAT_EN.
module fram_portb_arbiter
  import fram_portb_arbiter_pkg::*;
#(
  parameter int unsigned FRAM_ADDR_WIDTH = FRAM_ADDR_W,
  parameter int unsigned BANK_NUM        = BANK_N,
  parameter int unsigned BANK_ADDR_WIDTH = BANK_ADDR_W,
  parameter int unsigned DATA_WIDTH      = DATA_W,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned BUSY_SLACK      = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       rd_req,
  input  logic [BANK_ADDR_WIDTH-1:0]                 rd_bankaddr,
  input  logic                                       wb_valid,
  input  logic [FRAM_ADDR_WIDTH-1:0]                 wb_addr,
  input  logic [DATA_WIDTH-1:0]                      wb_data,
  input  logic                                       flush,
  output logic                                       wb_busy,
  output logic                                       drain_done,
  output logic                                       wb_overflow,
  output logic [BANK_NUM-1:0][BANK_ADDR_WIDTH-1:0]   bram_addr,
  output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]        bram_wdata,
  output logic [BANK_NUM-1:0]                        bram_we,
  output logic [BANK_NUM-1:0]                        bram_en
`ifdef FRAM_ARB_STAT_EN
  ,
  output logic [31:0]                                stat_stall_cycles,
  output logic [$clog2(FIFO_DEPTH):0]                stat_max_occupancy
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t        push_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] count, count_next;
  logic             do_push, do_pop;
  arb_state_t       state, state_next;

  assign do_pop     = !rd_req && !fifo_empty;
  assign do_push    = wb_valid && (!fifo_full || do_pop);
  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);

  always_comb begin
    push_entry.bank_addr = fram_bankaddr_of(wb_addr);
    push_entry.bank      = fram_bank_of(wb_addr);
    push_entry.data      = wb_data;
  end

  sync_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    drain_done = 1'b0;
    unique case (state)
      IDLE:    if (flush) state_next = DRAIN;
               else if (do_push) state_next = ACTIVE;
      ACTIVE:  if (flush) state_next = DRAIN;
               else if (count_next == '0) state_next = IDLE;
      DRAIN:   if (count == '0 && !wb_valid) begin
                 drain_done = 1'b1;
                 state_next = IDLE;
               end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_busy     <= 1'b0;
      wb_overflow <= 1'b0;
    end else begin
      wb_busy <= (CNT_W'(FIFO_DEPTH) - count_next <= CNT_W'(BUSY_SLACK)) || (state_next == DRAIN);
      if (wb_valid && fifo_full && !do_pop) wb_overflow <= 1'b1;
    end
  end

  // Reads broadcast one address to every bank; a queued write drives only its own bank.
  always_comb begin
    bram_en    = '0;
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (rd_req) begin
      bram_en   = '1;
      bram_addr = {BANK_NUM{rd_bankaddr}};
    end else if (!fifo_empty) begin
      bram_en[head.bank]    = 1'b1;
      bram_we[head.bank]    = 1'b1;
      bram_addr[head.bank]  = head.bank_addr;
      bram_wdata[head.bank] = head.data;
    end
  end

`ifdef FRAM_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles  <= '0;
      stat_max_occupancy <= '0;
    end else if (flush) begin
      stat_stall_cycles  <= '0;
      stat_max_occupancy <= '0;
    end else begin
      if (count != '0 && rd_req && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (count > stat_max_occupancy) stat_max_occupancy <= count;
    end
  end
`else
`endif

endmodule
